dmem_port_arbiter: RTL

Round-robin arbiter that shares one local data-memory port between up to `NUM_REQ` address-generation streams (load/store AGUs). A stream is granted for its whole vector access, or until a beat quota expires when preemption is compiled in. Non-granted streams are held through their stall inputs. Load data is returned to the issuing stream through a latency-matched tag pipeline. The block sits between the AGUs and the DMem bank.

---
 rtl/dmem_port_arbiter_if.sv | 44 ++++
 rtl/dmem_port_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_arbiter_if
//  Purpose  : AGU-side and DMem-side bundle for dmem_port_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]             I_Active;
    logic [NUM_REQ-1:0]             I_Req;
    logic [NUM_REQ-1:0]             I_We;
    logic [NUM_REQ-1:0][ADDR_W-1:0] I_Address;
    logic [NUM_REQ-1:0][DATA_W-1:0] I_St_Data;
    logic [NUM_REQ-1:0]             I_End_Access;
    logic [NUM_REQ-1:0]             O_Stall;
    logic                           O_Mem_Req;
    logic                           O_Mem_We;
    logic [ADDR_W-1:0]              O_Mem_Addr;
    logic [DATA_W-1:0]              O_Mem_St_Data;
    logic                           I_Mem_Stall;
    logic [DATA_W-1:0]              I_Mem_Ld_Data;
    logic [NUM_REQ-1:0]             O_Ld_Valid;
    logic [DATA_W-1:0]              O_Ld_Data;

    // arbiter side
    modport slave (
        input  I_Active, I_Req, I_We, I_Address, I_St_Data, I_End_Access,
        input  I_Mem_Stall, I_Mem_Ld_Data,
        output O_Stall, O_Mem_Req, O_Mem_We, O_Mem_Addr, O_Mem_St_Data,
        output O_Ld_Valid, O_Ld_Data
    );

    // AGU / memory environment side
    modport master (
        output I_Active, I_Req, I_We, I_Address, I_St_Data, I_End_Access,
        output I_Mem_Stall, I_Mem_Ld_Data,
        input  O_Stall, O_Mem_Req, O_Mem_We, O_Mem_Addr, O_Mem_St_Data,
        input  O_Ld_Valid, O_Ld_Data
    );
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_arbiter
//  Purpose  : Round-robin share of one DMem port between NUM_REQ AGU streams,
//             with tag pipeline routing load data back to the issuer.
//             Define DMEM_ARB_PREEMPT_EN to enable the MAX_BEATS grant quota.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1
`ifdef DMEM_ARB_PREEMPT_EN
    ,
    parameter int MAX_BEATS = 64
`endif
) (
    input  wire logic           clock,
    input  wire logic           reset,
    dmem_port_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [NUM_REQ-1:0] C_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [0:0]                   state_q,   state_d;
    logic [IDX_W-1:0]             gnt_q,     gnt_d;
    logic [IDX_W-1:0]             last_q,    last_d;
    logic [RD_LAT-1:0]            tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0][IDX_W-1:0] tag_idx_q, tag_idx_d;

    logic                         w_hit;
    logic [IDX_W-1:0]             w_pick;
    logic [IDX_W-1:0]             w_cand;
    logic                         w_granted;
    logic                         w_accept;
    logic [NUM_REQ-1:0]           w_gnt_oh;
    logic [NUM_REQ-1:0]           w_stall;
    logic                         w_mem_we;
    logic [ADDR_W-1:0]            w_mem_addr;
    logic [DATA_W-1:0]            w_mem_st_data;
    logic [NUM_REQ-1:0]           w_ld_valid;

`ifdef DMEM_ARB_PREEMPT_EN
    localparam int               CNT_W   = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MAX_BEATS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_others;
`endif

    // Search starts one past the last winner so every stream gets a turn.
    always_comb begin
        w_hit  = 1'b0;
        w_pick = last_q;
        w_cand = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((32'(last_q) + 32'(k)) % 32'(NUM_REQ));
            if (!w_hit && bus.I_Active[w_cand]) begin
                w_hit  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    always_comb begin
        w_granted     = (state_q == ST_GRANT);
        w_gnt_oh      = C_ONE << gnt_q;
        w_accept      = w_granted & bus.I_Req[gnt_q] & ~bus.I_Mem_Stall;
        w_stall       = '1;
        w_mem_we      = 1'b0;
        w_mem_addr    = {ADDR_W{1'b0}};
        w_mem_st_data = {DATA_W{1'b0}};
        if (w_granted) begin
            w_stall[gnt_q] = bus.I_Mem_Stall;
            w_mem_we       = bus.I_We[gnt_q];
            w_mem_addr     = bus.I_Address[gnt_q];
            w_mem_st_data  = bus.I_St_Data[gnt_q];
        end
    end

`ifdef DMEM_ARB_PREEMPT_EN
    assign w_others = |(bus.I_Active & ~w_gnt_oh);
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
`ifdef DMEM_ARB_PREEMPT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_hit) begin
                    state_d = ST_GRANT;
                    gnt_d   = w_pick;
                    last_d  = w_pick;
`ifdef DMEM_ARB_PREEMPT_EN
                    cnt_d   = '0;
`endif
                end
            end
            default: begin
`ifdef DMEM_ARB_PREEMPT_EN
                if (w_accept && (cnt_q != C_CNT_MAX))
                    cnt_d = cnt_q + 1'b1;
                // Quota spent while someone else waits: yield, AGU state stays frozen.
                if (w_accept && (cnt_q == C_CNT_LAST) && w_others)
                    state_d = ST_IDLE;
`endif
                if (bus.I_End_Access[gnt_q])
                    state_d = ST_IDLE;
            end
        endcase
    end

    // Tags shift every cycle independent of the FSM so in-flight loads survive release.
    always_comb begin
        tag_vld_d = tag_vld_q;
        tag_idx_d = tag_idx_q;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
        end
        tag_vld_d[0] = w_accept & ~bus.I_We[gnt_q];
        tag_idx_d[0] = gnt_q;
    end

    // Gated by reset so a load reaching the tail during reset is dropped.
    always_comb begin
        w_ld_valid = '0;
        if (tag_vld_q[RD_LAT-1] && !reset)
            w_ld_valid = C_ONE << tag_idx_q[RD_LAT-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            tag_vld_q <= '0;
            tag_idx_q <= '0;
`ifdef DMEM_ARB_PREEMPT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            tag_vld_q <= tag_vld_d;
            tag_idx_q <= tag_idx_d;
`ifdef DMEM_ARB_PREEMPT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.O_Stall       = w_stall;
    assign bus.O_Mem_Req     = w_accept;
    assign bus.O_Mem_We      = w_mem_we;
    assign bus.O_Mem_Addr    = w_mem_addr;
    assign bus.O_Mem_St_Data = w_mem_st_data;
    assign bus.O_Ld_Valid    = w_ld_valid;
    assign bus.O_Ld_Data     = bus.I_Mem_Ld_Data;

endmodule
`default_nettype wire
